// File: rtl/arya_thread_dispatcher.sv
// rtl/arya_thread_dispatcher.sv - job FIFO feeding per-thread start/busy/done slots
// Launches queued jobs on the lowest free thread and serializes tagged completions.
module arya_thread_dispatcher #(
  parameter int NUM_THREADS  = 8,
  parameter int JOB_ID_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 en,
  input  logic                                 job_valid,
  input  logic [JOB_ID_WIDTH-1:0]              job_id,
  output logic                                 job_ready,
  input  logic [NUM_THREADS-1:0]               thread_busy,
  input  logic [NUM_THREADS-1:0]               thread_done,
  output logic [NUM_THREADS-1:0]               start_thread,
  output logic [NUM_THREADS*JOB_ID_WIDTH-1:0]  thread_job_id,
  output logic                                 done_valid,
  output logic [JOB_ID_WIDTH-1:0]              done_job_id,
  output logic [$clog2(NUM_THREADS+1)-1:0]     jobs_in_flight,
  output logic                                 all_idle,
  output logic                                 protocol_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(NUM_THREADS);
  localparam int JIF_W = $clog2(NUM_THREADS + 1);

  typedef enum logic [1:0] {
    S_FREE      = 2'd0,
    S_LAUNCHED  = 2'd1,
    S_RUNNING   = 2'd2,
    S_DONE_PEND = 2'd3
  } slot_state_t;

  slot_state_t state      [NUM_THREADS];
  slot_state_t state_next [NUM_THREADS];

  logic [JOB_ID_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty, push, dispatch;
  logic                    free_found, pend_found, err_set;
  logic [IDX_W-1:0]        free_idx, pend_idx;

  assign job_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = job_valid && job_ready;
  assign dispatch   = en && !fifo_empty && free_found;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    for (int i = NUM_THREADS - 1; i >= 0; i--) begin
      if (state[i] == S_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (state[i] == S_DONE_PEND) begin
        pend_found = 1'b1;
        pend_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    err_set = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      state_next[i] = state[i];
      case (state[i])
        S_FREE: begin
          if (thread_done[i]) err_set = 1'b1;
          if (dispatch && free_idx == IDX_W'(i)) state_next[i] = S_LAUNCHED;
        end
        S_LAUNCHED: begin
          if (thread_done[i])      state_next[i] = S_DONE_PEND;
          else if (thread_busy[i]) state_next[i] = S_RUNNING;
        end
        S_RUNNING: begin
          if (thread_done[i]) state_next[i] = S_DONE_PEND;
        end
        S_DONE_PEND: begin
          if (pend_found && pend_idx == IDX_W'(i)) state_next[i] = S_FREE;
        end
        default: state_next[i] = S_FREE;
      endcase
    end
  end

  always_comb begin
    jobs_in_flight = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (state[i] != S_FREE) jobs_in_flight = jobs_in_flight + JIF_W'(1);
    end
  end

  assign all_idle = fifo_empty && (jobs_in_flight == '0);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= job_id;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) state[i] <= S_FREE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      start_thread  <= '0;
      thread_job_id <= '0;
      done_valid    <= 1'b0;
      done_job_id   <= '0;
      protocol_err  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) state[i] <= state_next[i];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (dispatch) rd_ptr <= rd_ptr + 1'b1;
      case ({push, dispatch})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      start_thread <= dispatch ? (NUM_THREADS'(1) << free_idx) : '0;
      if (dispatch) thread_job_id[free_idx*JOB_ID_WIDTH +: JOB_ID_WIDTH] <= fifo_mem[rd_ptr];
      done_valid <= pend_found;
      if (pend_found) done_job_id <= thread_job_id[pend_idx*JOB_ID_WIDTH +: JOB_ID_WIDTH];
      protocol_err <= protocol_err | err_set;
    end
  end
endmodule

// File: tb/tb_arya_thread_dispatcher.sv
// tb/tb_arya_thread_dispatcher.sv - directed self-checking bench for arya_thread_dispatcher
// Inputs change 1ns after each rising edge; outputs are sampled at that same point.
module tb_arya_thread_dispatcher;
  logic        clk = 1'b0;
  logic        reset, en, job_valid;
  logic [7:0]  job_id;
  logic        job_ready;
  logic [7:0]  thread_busy, thread_done, start_thread;
  logic [63:0] thread_job_id;
  logic        done_valid;
  logic [7:0]  done_job_id;
  logic [3:0]  jobs_in_flight;
  logic        all_idle, protocol_err;

  int n_pass  = 0;
  int n_total = 0;

  arya_thread_dispatcher #(.NUM_THREADS(8), .JOB_ID_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .job_valid(job_valid), .job_id(job_id),
    .job_ready(job_ready), .thread_busy(thread_busy), .thread_done(thread_done),
    .start_thread(start_thread), .thread_job_id(thread_job_id), .done_valid(done_valid),
    .done_job_id(done_job_id), .jobs_in_flight(jobs_in_flight), .all_idle(all_idle),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_start"}, start_thread, 0);
    check_eq({tag, "_dv"}, done_valid, 0);
    check_eq({tag, "_did"}, done_job_id, 0);
    check_eq({tag, "_tjid"}, thread_job_id, 0);
    check_eq({tag, "_perr"}, protocol_err, 0);
    check_eq({tag, "_ready"}, job_ready, 1);
    check_eq({tag, "_idle"}, all_idle, 1);
    check_eq({tag, "_jif"}, jobs_in_flight, 0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; job_valid = 1'b0; job_id = 8'h00;
    thread_busy = 8'h00; thread_done = 8'h00;
    repeat (3) step();
    check_reset_values("rst");
    reset = 1'b0;
    step();

    // T1 single job
    job_valid = 1'b1; job_id = 8'h2A;
    step();
    job_valid = 1'b0;
    check_eq("t1_start_early", start_thread, 8'h00);
    check_eq("t1_idle_queued", all_idle, 0);
    step();
    check_eq("t1_start", start_thread, 8'h01);
    check_eq("t1_tjid0", thread_job_id[7:0], 8'h2A);
    check_eq("t1_jif", jobs_in_flight, 1);
    thread_busy = 8'h01;
    step();
    check_eq("t1_start_pulse", start_thread, 8'h00);
    repeat (31) step();
    thread_busy = 8'h00; thread_done = 8'h01;
    step();
    thread_done = 8'h00;
    check_eq("t1_dv_early", done_valid, 0);
    step();
    check_eq("t1_dv", done_valid, 1);
    check_eq("t1_did", done_job_id, 8'h2A);
    step();
    check_eq("t1_dv_pulse", done_valid, 0);
    check_eq("t1_idle", all_idle, 1);

    // T2 fill all threads, ninth job waits for a free slot
    for (int k = 1; k <= 9; k++) begin
      job_valid = 1'b1; job_id = 8'(k);
      step();
      if (k >= 2) begin
        check_eq($sformatf("t2_start_%0d", k), start_thread, 64'(1) << (k - 2));
        check_eq($sformatf("t2_tjid_%0d", k), thread_job_id[(k-2)*8 +: 8], k - 1);
      end
    end
    job_valid = 1'b0;
    step();
    check_eq("t2_start_wait", start_thread, 8'h00);
    check_eq("t2_jif_full", jobs_in_flight, 8);
    check_eq("t2_ready", job_ready, 1);
    thread_done = 8'h01;
    step();
    thread_done = 8'h00;
    check_eq("t2_dv_early", done_valid, 0);
    step();
    check_eq("t2_dv", done_valid, 1);
    check_eq("t2_did", done_job_id, 8'h01);
    check_eq("t2_start_not_yet", start_thread, 8'h00);
    step();
    check_eq("t2_relaunch", start_thread, 8'h01);
    check_eq("t2_relaunch_id", thread_job_id[7:0], 8'h09);
    thread_done = 8'hFF;
    step();
    thread_done = 8'h00;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq($sformatf("t2_drain_dv_%0d", i), done_valid, 1);
      check_eq($sformatf("t2_drain_id_%0d", i), done_job_id, (i == 0) ? 9 : i + 1);
    end
    step();
    check_eq("t2_drain_end", done_valid, 0);
    check_eq("t2_idle", all_idle, 1);

    // T3 FIFO full with dispatch frozen
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      job_valid = 1'b1; job_id = 8'h11 + 8'(k);
      check_eq($sformatf("t3_ready_%0d", k), job_ready, (k < 4) ? 1 : 0);
      step();
    end
    job_valid = 1'b0;
    check_eq("t3_ready_full", job_ready, 0);
    check_eq("t3_frozen", start_thread, 8'h00);
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq($sformatf("t3_start_%0d", k), start_thread, 64'(1) << k);
      check_eq($sformatf("t3_tjid_%0d", k), thread_job_id[k*8 +: 8], 8'h11 + k);
    end
    step();
    check_eq("t3_no_fifth", start_thread, 8'h00);
    check_eq("t3_jif", jobs_in_flight, 4);
    check_eq("t3_ready_after", job_ready, 1);

    // T4 simultaneous done on threads 0 and 2
    thread_done = 8'b0000_0101;
    step();
    thread_done = 8'h00;
    check_eq("t4_jif_pend", jobs_in_flight, 4);
    check_eq("t4_dv_early", done_valid, 0);
    step();
    check_eq("t4_dv0", done_valid, 1);
    check_eq("t4_id0", done_job_id, 8'h11);
    check_eq("t4_jif0", jobs_in_flight, 3);
    step();
    check_eq("t4_dv2", done_valid, 1);
    check_eq("t4_id2", done_job_id, 8'h13);
    check_eq("t4_jif2", jobs_in_flight, 2);
    step();
    check_eq("t4_dv_end", done_valid, 0);
    thread_done = 8'b0000_1010;
    step();
    thread_done = 8'h00;
    step();
    check_eq("t4_id1", done_job_id, 8'h12);
    step();
    check_eq("t4_id3", done_job_id, 8'h14);
    step();
    check_eq("t4_idle", all_idle, 1);

    // T5 done on a FREE slot
    check_eq("t5_perr_before", protocol_err, 0);
    thread_done = 8'h20;
    step();
    thread_done = 8'h00;
    check_eq("t5_perr", protocol_err, 1);
    check_eq("t5_dv", done_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("t5_perr_sticky_%0d", i), protocol_err, 1);
      check_eq($sformatf("t5_no_report_%0d", i), done_valid, 0);
    end

    // T6 reset with three running slots and two queued jobs
    for (int k = 0; k < 3; k++) begin
      job_valid = 1'b1; job_id = 8'h31 + 8'(k);
      step();
    end
    job_valid = 1'b0;
    step();
    thread_busy = 8'h07;
    step();
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      job_valid = 1'b1; job_id = 8'h34 + 8'(k);
      step();
    end
    job_valid = 1'b0;
    check_eq("t6_jif_pre", jobs_in_flight, 3);
    check_eq("t6_idle_pre", all_idle, 0);
    reset = 1'b1;
    step();
    check_reset_values("t6");
    reset = 1'b0; thread_busy = 8'h00; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq($sformatf("t6_no_report_%0d", i), done_valid, 0);
      check_eq($sformatf("t6_no_launch_%0d", i), start_thread, 8'h00);
      check_eq($sformatf("t6_idle_%0d", i), all_idle, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
